// File: rtl/addsub_arbiter.sv
// addsub_arbiter: shares one external 64-bit add/sub unit between two
// requesters (execute stage and address generation). One operation is in
// flight at a time: IDLE accepts a request, ISSUE drives the unit and
// captures its result, and RESP presents the result to the granted requester.
// Build option: define ADDSUB_ARB_RR_EN for round-robin arbitration between
// the requesters. Without it, requester 0 has fixed priority.
module addsub_arbiter (
    input  logic        clk,
    input  logic        rst,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [63:0] req0_a,
    input  logic [63:0] req0_b,
    input  logic        req0_sub,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [63:0] req1_a,
    input  logic [63:0] req1_b,
    input  logic        req1_sub,

    output logic [63:0] au_a,
    output logic [63:0] au_b,
    output logic [3:0]  au_ctrl,
    input  logic [63:0] au_result,
    input  logic        au_cout,

    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [63:0] rsp_result,
    output logic        rsp_cout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic   op_sub;
    logic   grant_id;
    logic   pick1;
    logic   accept;

`ifdef ADDSUB_ARB_RR_EN
    logic   last_grant;

    // Round-robin choice: on a tie the requester not granted last time wins.
    always_comb begin
        pick1 = 1'b0;
        if (req0_valid && req1_valid) begin
            pick1 = ~last_grant;
        end else begin
            pick1 = req1_valid;
        end
    end

    // Remember who was granted most recently; reset favours requester 0 next.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= pick1;
        end
    end
`else
    // Fixed priority: requester 1 wins only when requester 0 is idle.
    always_comb begin
        pick1 = 1'b0;
        pick1 = req1_valid && !req0_valid;
    end
`endif

    // State register; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus handshake and unit-control outputs.
    always_comb begin
        state_next = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        au_ctrl    = 4'b0000;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                req0_ready = req0_valid && !pick1;
                req1_ready = req1_valid && pick1;
                accept     = req0_ready || req1_ready;
                if (accept) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                au_ctrl    = op_sub ? 4'b1100 : 4'b0000;
                state_next = RESP;
            end
            RESP: begin
                rsp0_valid = !grant_id;
                rsp1_valid = grant_id;
                if ((!grant_id && rsp0_ready) || (grant_id && rsp1_ready)) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand capture on accept and result capture at the end of ISSUE.
    // The operand registers feed the unit directly, so they hold their last
    // value once the operation has moved on.
    always_ff @(posedge clk) begin
        if (rst) begin
            au_a       <= 64'd0;
            au_b       <= 64'd0;
            op_sub     <= 1'b0;
            grant_id   <= 1'b0;
            rsp_result <= 64'd0;
            rsp_cout   <= 1'b0;
        end else begin
            if (accept) begin
                au_a     <= pick1 ? req1_a : req0_a;
                au_b     <= pick1 ? req1_b : req0_b;
                op_sub   <= pick1 ? req1_sub : req0_sub;
                grant_id <= pick1;
            end
            if (state == ISSUE) begin
                rsp_result <= au_result;
                rsp_cout   <= au_cout;
            end
        end
    end

endmodule

// File: tb/tb_addsub_arbiter.sv
// tb_addsub_arbiter: self-checking bench for addsub_arbiter. The shared
// add/sub unit is modelled here, and a transaction-level reference
// predicts handshakes, unit control and results for every cycle.
// Honours ADDSUB_ARB_RR_EN the same way as the design.
module tb_addsub_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req0_sub;
    logic [63:0] req0_a, req0_b;
    logic        req1_valid, req1_ready, req1_sub;
    logic [63:0] req1_a, req1_b;
    logic [63:0] au_a, au_b, au_result;
    logic [3:0]  au_ctrl;
    logic        au_cout;
    logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [63:0] rsp_result;
    logic        rsp_cout;
    logic [64:0] au_sum;

`ifdef ADDSUB_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: operation in flight, cycles since accept, captured values.
    bit          m_busy;
    int          m_age;
    bit          m_id;
    bit          m_sub;
    bit          m_last;
    logic [63:0] m_a, m_b, m_res, m_pres;
    logic        m_cout, m_pcout;
    int          grants_dut[$];

    addsub_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
        .req0_b(req0_b), .req0_sub(req0_sub),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
        .req1_b(req1_b), .req1_sub(req1_sub),
        .au_a(au_a), .au_b(au_b), .au_ctrl(au_ctrl),
        .au_result(au_result), .au_cout(au_cout),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_result(rsp_result), .rsp_cout(rsp_cout)
    );

    always #5 clk = ~clk;

    // External shared adder: b optionally inverted, plus carry-in.
    always_comb begin
        au_sum = {1'b0, au_a} + {1'b0, (au_ctrl[3] ? ~au_b : au_b)} + {64'd0, au_ctrl[2]};
    end
    assign au_result = au_sum[63:0];
    assign au_cout   = au_sum[64];

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Mathematical reference: subtraction as addition of 2^64 - b.
    task automatic refOp(input logic [63:0] a, input logic [63:0] b, input bit sub,
                         output logic [63:0] res, output logic cout);
        logic [64:0] s;
        if (sub) s = {1'b0, a} + (65'h1_0000_0000_0000_0000 - {1'b0, b});
        else     s = {1'b0, a} + {1'b0, b};
        res  = s[63:0];
        cout = s[64];
    endtask

    task automatic modelReset();
        m_busy = 0; m_age = 0; m_id = 0; m_sub = 0; m_last = 1'b1;
        m_a = '0; m_b = '0; m_res = '0; m_cout = 1'b0;
        m_pres = '0; m_pcout = 1'b0;
    endtask

    // One clock cycle: drive inputs, check every output against the
    // reference, then advance the reference across the clock edge.
    task automatic applyStimulus(input bit r,
                                 input bit v0, input logic [63:0] a0, input logic [63:0] b0, input bit s0,
                                 input bit v1, input logic [63:0] a1, input logic [63:0] b1, input bit s1,
                                 input bit rr0, input bit rr1);
        bit pick1, er0, er1, ev0, ev1;
        logic [3:0] ectrl;
        rst = r;
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_sub = s0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_sub = s1;
        rsp0_ready = rr0; rsp1_ready = rr1;
        #1;
        if (v0 && v1) pick1 = RR ? !m_last : 1'b0;
        else          pick1 = v1;
        er0 = !m_busy && v0 && !pick1;
        er1 = !m_busy && v1 && pick1;
        ev0 = m_busy && (m_age >= 2) && !m_id;
        ev1 = m_busy && (m_age >= 2) && m_id;
        ectrl = (m_busy && m_age == 1 && m_sub) ? 4'b1100 : 4'b0000;
        checkOutput("req0_ready", 64'(req0_ready), 64'(er0));
        checkOutput("req1_ready", 64'(req1_ready), 64'(er1));
        checkOutput("rsp0_valid", 64'(rsp0_valid), 64'(ev0));
        checkOutput("rsp1_valid", 64'(rsp1_valid), 64'(ev1));
        checkOutput("au_ctrl", 64'(au_ctrl), 64'(ectrl));
        checkOutput("au_a", au_a, m_a);
        checkOutput("au_b", au_b, m_b);
        checkOutput("rsp_result", rsp_result, m_res);
        checkOutput("rsp_cout", 64'(rsp_cout), 64'(m_cout));
        if (!r && (req0_ready || req1_ready)) grants_dut.push_back(req1_ready ? 1 : 0);
        @(posedge clk);
        #1;
        if (r) begin
            modelReset();
        end else if (!m_busy) begin
            if (er0 || er1) begin
                m_busy = 1; m_age = 1; m_id = er1; m_last = er1;
                m_a = er1 ? a1 : a0;
                m_b = er1 ? b1 : b0;
                m_sub = er1 ? s1 : s0;
                refOp(m_a, m_b, m_sub, m_pres, m_pcout);
            end
        end else if (m_age == 1) begin
            m_age = 2; m_res = m_pres; m_cout = m_pcout;
        end else if ((!m_id && rr0) || (m_id && rr1)) begin
            m_busy = 0;
        end
    endtask

    task automatic idleCycle(input bit r);
        applyStimulus(r, 0, '0, '0, 0, 0, '0, '0, 0, 0, 0);
    endtask

    // A single directed operation with hard-coded expected result; holds the
    // response for 'hold' cycles while both requesters keep asking and the
    // non-granted response ready is asserted.
    task automatic runOp(input bit id, input logic [63:0] a, input logic [63:0] b, input bit sub,
                         input logic [63:0] exp_res, input bit exp_cout, input int hold, input string tag);
        if (id) applyStimulus(0, 0, '0, '0, 0, 1, a, b, sub, 1, 1);
        else    applyStimulus(0, 1, a, b, sub, 0, '0, '0, 0, 1, 1);
        idleCycle(0);
        checkOutput({tag, "_valid"}, 64'(id ? rsp1_valid : rsp0_valid), 64'd1);
        checkOutput({tag, "_res"}, rsp_result, exp_res);
        checkOutput({tag, "_cout"}, 64'(rsp_cout), 64'(exp_cout));
        for (int i = 0; i < hold; i++) begin
            applyStimulus(0, 1, 64'(i), 64'd7, 0, 1, 64'd9, 64'(i), 1, id ? 1'b1 : 1'b0, id ? 1'b0 : 1'b1);
        end
        if (hold > 0) checkOutput({tag, "_held"}, rsp_result, exp_res);
        if (id) applyStimulus(0, 0, '0, '0, 0, 0, '0, '0, 0, 0, 1);
        else    applyStimulus(0, 0, '0, '0, 0, 0, '0, '0, 0, 1, 0);
    endtask

    function automatic logic [63:0] rnd64();
        case ($urandom_range(5))
            0:       return 64'd0;
            1:       return 64'hFFFF_FFFF_FFFF_FFFF;
            2:       return 64'd1;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        int exp_g[4];
        rst = 1'b1;
        req0_valid = 0; req0_a = '0; req0_b = '0; req0_sub = 0;
        req1_valid = 0; req1_a = '0; req1_b = '0; req1_sub = 0;
        rsp0_ready = 0; rsp1_ready = 0;
        @(posedge clk);
        #1;
        modelReset();
        idleCycle(1);
        idleCycle(0);

        // Add, both subtract cases, wrap-around add.
        runOp(0, 64'd5, 64'd3, 0, 64'd8, 0, 0, "add_5_3");
        runOp(1, 64'd3, 64'd5, 1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, "sub_3_5");
        runOp(0, 64'd5, 64'd3, 1, 64'd2, 1, 0, "sub_5_3");
        runOp(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 64'd0, 1, 0, "add_wrap");

        // Response back-pressure for five cycles.
        runOp(0, 64'd7, 64'd9, 0, 64'd16, 0, 5, "stall");

        // Reset during ISSUE discards the operation; the next one completes.
        applyStimulus(0, 1, 64'd100, 64'd1, 0, 0, '0, '0, 0, 0, 0);
        applyStimulus(1, 0, '0, '0, 0, 0, '0, '0, 0, 1, 1);
        checkOutput("abort_rsp0", 64'(rsp0_valid), 64'd0);
        checkOutput("abort_res", rsp_result, 64'd0);
        idleCycle(0);
        runOp(1, 64'd40, 64'd2, 1, 64'd38, 1, 0, "post_abort");

        // Both requesters continuously valid from a fresh reset.
        idleCycle(1);
        grants_dut.delete();
        for (int i = 0; i < 12; i++) begin
            applyStimulus(0, 1, 64'(i), 64'd1, 0, 1, 64'(i), 64'd2, 0, 1, 1);
        end
        if (RR) begin
            exp_g[0] = 0; exp_g[1] = 1; exp_g[2] = 0; exp_g[3] = 1;
        end else begin
            exp_g[0] = 0; exp_g[1] = 0; exp_g[2] = 0; exp_g[3] = 0;
        end
        checkOutput("grant_count", 64'(grants_dut.size()), 64'd4);
        for (int i = 0; i < 4 && i < grants_dut.size(); i++) begin
            checkOutput($sformatf("grant_%0d", i), 64'(grants_dut[i]), 64'(exp_g[i]));
        end

        // Random traffic, including withdrawals and stray response readies.
        for (int i = 0; i < 500; i++) begin
            applyStimulus($urandom_range(59) == 0,
                          $urandom_range(9) < 6, rnd64(), rnd64(), 1'($urandom_range(1)),
                          $urandom_range(9) < 6, rnd64(), rnd64(), 1'($urandom_range(1)),
                          1'($urandom_range(1)), 1'($urandom_range(1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
